// File: rtl/bank_rw_scheduler.sv
// Read/write mode scheduler for 16 bank queues: write-drain watermarks, bus turnaround,
// per-type round-robin grant and outstanding-request flow control back to the mapper.
module bank_rw_scheduler #(
    parameter int NUM_BANKS   = 16,
    parameter int BANK_W      = 4,
    parameter int CNT_W       = 7,
    parameter int RD_MAX      = 32,
    parameter int WR_MAX      = 32,
    parameter int WR_HIGH     = 24,
    parameter int WR_LOW      = 8,
    parameter int TURN_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enq_valid,
    input  logic                 enq_type,
    input  logic [BANK_W-1:0]    enq_bank,
    input  logic [NUM_BANKS-1:0] rd_pending,
    input  logic [NUM_BANKS-1:0] wr_pending,
    input  logic                 issue_ready,
    output logic                 issue_valid,
    output logic [BANK_W-1:0]    issue_bank,
    output logic                 issue_type,
    output logic                 stop_reading,
    output logic                 stop_writing,
    output logic [1:0]           sched_mode,
    output logic                 ovf_err
);

    typedef enum logic [1:0] {
        ST_READ  = 2'd0,
        ST_R2W   = 2'd1,
        ST_WRITE = 2'd2,
        ST_W2R   = 2'd3
    } state_t;

    localparam int TURN_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    state_t                 state_reg, state_next;
    logic [TURN_W-1:0]      turn_reg, turn_next;
    logic [CNT_W-1:0]       rd_cnt_reg, rd_cnt_next;
    logic [CNT_W-1:0]       wr_cnt_reg, wr_cnt_next;
    logic [BANK_W-1:0]      rd_ptr_reg, wr_ptr_reg;
    logic                   issue_valid_reg, issue_type_reg;
    logic [BANK_W-1:0]      issue_bank_reg;
    logic                   ovf_reg;

    logic                   handshake, hold, ovf_set;
    logic                   grant_rd, grant_ok;
    logic [BANK_W-1:0]      sel_ptr, win_off, win_bank;
    logic [NUM_BANKS-1:0]   hs_mask, sel_pend, rot;

    // Outstanding counts are global; the bank index is not needed for them.
    logic unused_enq_bank;
    assign unused_enq_bank = ^enq_bank;

    assign handshake = issue_valid_reg & issue_ready;
    assign hold      = issue_valid_reg & ~issue_ready;

    function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] c,
                                                  input logic inc, input logic dec);
        logic [CNT_W-1:0] r;
        r = c;
        if (inc && !dec && c != CNT_SAT)
            r = c + CNT_W'(1);
        else if (dec && !inc && c != '0)
            r = c - CNT_W'(1);
        return r;
    endfunction

    assign rd_cnt_next = cnt_step(rd_cnt_reg, enq_valid & ~enq_type, handshake & ~issue_type_reg);
    assign wr_cnt_next = cnt_step(wr_cnt_reg, enq_valid &  enq_type, handshake &  issue_type_reg);

    assign stop_reading = (rd_cnt_reg >= CNT_W'(RD_MAX));
    assign stop_writing = (wr_cnt_reg >= CNT_W'(WR_MAX));
    assign ovf_set      = enq_valid & (enq_type ? stop_writing : stop_reading);

    // Mode changes wait until any presented grant has been accepted.
    always_comb begin
        state_next = state_reg;
        turn_next  = turn_reg;
        case (state_reg)
            ST_READ: begin
                if (!hold && (wr_cnt_reg >= CNT_W'(WR_HIGH) ||
                              (rd_pending == '0 && wr_pending != '0))) begin
                    state_next = ST_R2W;
                    turn_next  = TURN_W'(TURN_CYCLES - 1);
                end
            end
            ST_WRITE: begin
                if (!hold && rd_pending != '0 &&
                    (wr_pending == '0 || wr_cnt_reg <= CNT_W'(WR_LOW))) begin
                    state_next = ST_W2R;
                    turn_next  = TURN_W'(TURN_CYCLES - 1);
                end
            end
            ST_R2W: begin
                if (turn_reg == '0) state_next = ST_WRITE;
                else                turn_next  = turn_reg - TURN_W'(1);
            end
            default: begin
                if (turn_reg == '0) state_next = ST_READ;
                else                turn_next  = turn_reg - TURN_W'(1);
            end
        endcase
    end

    // The bank being accepted this cycle is excluded: its pending bit still shows the popped entry.
    assign hs_mask  = handshake ? (NUM_BANKS'(1) << issue_bank_reg) : '0;
    assign grant_rd = (state_next == ST_READ);
    assign sel_ptr  = grant_rd ? rd_ptr_reg : wr_ptr_reg;
    assign sel_pend = (grant_rd ? rd_pending : wr_pending) & ~hs_mask;
    assign grant_ok = (sel_pend != '0) && (state_next == ST_READ || state_next == ST_WRITE);

    // Rotate so bit 0 is the pointer position; NUM_BANKS == 2**BANK_W gives free wrap.
    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_rot
            logic [BANK_W-1:0] idx;
            assign idx     = sel_ptr + BANK_W'(gi);
            assign rot[gi] = sel_pend[idx];
        end
    endgenerate

    always_comb begin
        win_off = '0;
        for (int i = NUM_BANKS - 1; i >= 0; i--) begin
            if (rot[i]) win_off = BANK_W'(i);
        end
    end

    assign win_bank = sel_ptr + win_off;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= ST_READ;
            turn_reg        <= '0;
            rd_cnt_reg      <= '0;
            wr_cnt_reg      <= '0;
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
            issue_valid_reg <= 1'b0;
            issue_bank_reg  <= '0;
            issue_type_reg  <= 1'b0;
            ovf_reg         <= 1'b0;
        end else begin
            state_reg  <= state_next;
            turn_reg   <= turn_next;
            rd_cnt_reg <= rd_cnt_next;
            wr_cnt_reg <= wr_cnt_next;
            if (!hold) begin
                issue_valid_reg <= grant_ok;
                if (grant_ok) begin
                    issue_bank_reg <= win_bank;
                    issue_type_reg <= ~grant_rd;
                end
            end
            if (handshake) begin
                if (issue_type_reg) wr_ptr_reg <= issue_bank_reg + BANK_W'(1);
                else                rd_ptr_reg <= issue_bank_reg + BANK_W'(1);
            end
            if (ovf_set) ovf_reg <= 1'b1;
        end
    end

    assign issue_valid = issue_valid_reg;
    assign issue_bank  = issue_bank_reg;
    assign issue_type  = issue_type_reg;
    assign sched_mode  = state_reg;
    assign ovf_err     = ovf_reg;

endmodule

// File: tb/tb_bank_rw_scheduler.sv
// Scoreboard bench for bank_rw_scheduler: directed stimulus pushes expected grants,
// a negedge monitor pops and compares on every handshake.
module tb_bank_rw_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enq_valid, enq_type;
    logic [3:0]  enq_bank;
    logic [15:0] rd_pending, wr_pending;
    logic        issue_ready;
    logic        issue_valid, issue_type, stop_reading, stop_writing, ovf_err;
    logic [3:0]  issue_bank;
    logic [1:0]  sched_mode;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [4:0]  exp_q[$];
    logic [4:0]  mon_exp;
    logic        seen;

    bank_rw_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .enq_valid    (enq_valid),
        .enq_type     (enq_type),
        .enq_bank     (enq_bank),
        .rd_pending   (rd_pending),
        .wr_pending   (wr_pending),
        .issue_ready  (issue_ready),
        .issue_valid  (issue_valid),
        .issue_bank   (issue_bank),
        .issue_type   (issue_type),
        .stop_reading (stop_reading),
        .stop_writing (stop_writing),
        .sched_mode   (sched_mode),
        .ovf_err      (ovf_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic push(input logic t, input logic [3:0] b);
        exp_q.push_back({t, b});
    endtask

    task automatic enqueue(input logic t, input int n);
        enq_valid = 1'b1;
        enq_type  = t;
        enq_bank  = 4'd0;
        repeat (n) tick();
        enq_valid = 1'b0;
    endtask

    // Monitor: one line per accepted grant.
    always @(negedge clk) begin
        if (rst && issue_valid && issue_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL grant_unexpected: got type=%0d bank=%0d, required no grant",
                         issue_type, issue_bank);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({issue_type, issue_bank} !== mon_exp) begin
                    n_fail++;
                    $display("FAIL grant: got type=%0d bank=%0d, required type=%0d bank=%0d",
                             issue_type, issue_bank, mon_exp[4], mon_exp[3:0]);
                end else begin
                    $display("ok   grant type=%0d bank=%0d", issue_type, issue_bank);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        enq_valid   = 1'b0;
        enq_type    = 1'b0;
        enq_bank    = 4'd0;
        rd_pending  = 16'h0;
        wr_pending  = 16'h0;
        issue_ready = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_valid", 32'(issue_valid), 0);
        chk("rst_stop_rd", 32'(stop_reading), 0);
        chk("rst_stop_wr", 32'(stop_writing), 0);
        chk("rst_mode", 32'(sched_mode), 0);
        chk("rst_ovf", 32'(ovf_err), 0);
        rst = 1'b1;
        tick();

        // Round robin over banks 0,1,15
        push(0, 0); push(0, 1); push(0, 15); push(0, 0); push(0, 1); push(0, 15);
        rd_pending  = 16'h8003;
        issue_ready = 1'b1;
        chk("rr_valid_before", 32'(issue_valid), 0);
        tick();
        chk("rr_first_valid", 32'(issue_valid), 1);
        chk("rr_first_bank", 32'(issue_bank), 0);
        repeat (5) tick();
        rd_pending = 16'h0;
        tick();
        chk("rr_idle", 32'(issue_valid), 0);

        // Hold under stall, then continue from the new pending bank
        push(0, 3); push(0, 4);
        issue_ready = 1'b0;
        rd_pending  = 16'h0008;
        tick();
        chk("hold_valid", 32'(issue_valid), 1);
        chk("hold_bank0", 32'(issue_bank), 3);
        rd_pending = 16'h0010;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("hold_bank_c%0d", i + 1), 32'({issue_valid, issue_bank}), 32'h13);
        end
        issue_ready = 1'b1;
        tick();
        chk("hold_next_bank", 32'(issue_bank), 4);
        rd_pending = 16'h0;
        tick();
        issue_ready = 1'b0;

        // Simultaneous enqueue + issue at rd_cnt=5, then fill to 32
        enqueue(0, 5);
        push(0, 0);
        rd_pending = 16'h0001;
        tick();
        chk("sim_valid", 32'(issue_valid), 1);
        issue_ready = 1'b1;
        enq_valid   = 1'b1;
        enq_type    = 1'b0;
        rd_pending  = 16'h0;
        tick();
        issue_ready = 1'b0;
        enq_valid   = 1'b0;
        enqueue(0, 26);
        chk("bp_stop_at31", 32'(stop_reading), 0);
        enqueue(0, 1);
        chk("bp_stop_at32", 32'(stop_reading), 1);
        chk("bp_ovf_clear", 32'(ovf_err), 0);

        // Issue one read to release the stop, then overflow
        push(0, 0);
        rd_pending = 16'h0001;
        tick();
        issue_ready = 1'b1;
        rd_pending  = 16'h0;
        tick();
        issue_ready = 1'b0;
        chk("bp_stop_release", 32'(stop_reading), 0);
        enqueue(0, 1);
        chk("bp_stop_again", 32'(stop_reading), 1);
        chk("bp_ovf_not_yet", 32'(ovf_err), 0);
        enqueue(0, 1);
        chk("bp_ovf_set", 32'(ovf_err), 1);
        repeat (3) tick();
        chk("bp_ovf_sticky", 32'(ovf_err), 1);

        // Write drain: high watermark, turnaround, drain to low watermark, turn back
        for (int k = 0; k < 17; k++) push(1, (k % 2 == 0) ? 4'd1 : 4'd2);
        push(0, 0);
        enqueue(1, 24);
        chk("wd_mode_read", 32'(sched_mode), 0);
        rd_pending  = 16'h0001;
        wr_pending  = 16'h0006;
        issue_ready = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wd_r2w_c%0d", i), 32'({sched_mode, issue_valid}), 32'b010);
            tick();
        end
        chk("wd_write_mode", 32'(sched_mode), 2);
        chk("wd_first_wr", 32'({issue_valid, issue_type, issue_bank}), 32'h31);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            if (sched_mode == 2'd3) seen = 1'b1;
        end
        chk("wd_w2r_reached", 32'(seen), 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wd_w2r_c%0d", i), 32'({sched_mode, issue_valid}), 32'b110);
            tick();
        end
        chk("wd_read_mode", 32'(sched_mode), 0);
        chk("wd_read_grant", 32'({issue_valid, issue_type, issue_bank}), 32'h20);
        rd_pending = 16'h0;
        wr_pending = 16'h0;
        tick();
        issue_ready = 1'b0;

        // Reset mid-operation with wr_cnt=10 and a grant presented
        enqueue(1, 3);
        rd_pending = 16'h0001;
        tick();
        chk("mr_valid_pre", 32'(issue_valid), 1);
        chk("mr_stop_rd_pre", 32'(stop_reading), 1);
        #2 rst = 1'b0;
        #1;
        chk("mr_valid", 32'(issue_valid), 0);
        chk("mr_stops", 32'({stop_reading, stop_writing}), 0);
        chk("mr_ovf", 32'(ovf_err), 0);
        rd_pending = 16'h0;
        tick();
        rst = 1'b1;
        tick();
        chk("mr_mode_after", 32'(sched_mode), 0);
        enqueue(1, 23);
        repeat (3) tick();
        chk("mr_wr_23_stay", 32'(sched_mode), 0);
        enqueue(1, 1);
        tick();
        chk("mr_wr_24_r2w", 32'(sched_mode), 1);

        chk("sb_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bank_rw_scheduler.md
Name: bank_rw_scheduler

Overview:
- Sits between the 16 per-bank request queues fed by the mapper and the DRAM command layer.
- Decides whether the controller is in read or write mode, with write-drain watermarks and a fixed bus-turnaround gap.
- Selects one bank per cycle round-robin within the current mode.
- Counts outstanding reads and writes and drives stop_reading/stop_writing back to the mapper.

Parameters:
NUM_BANKS, 16, number of bank queues
BANK_W, 4, bank index width
CNT_W, 7, outstanding counter width
RD_MAX, 32, outstanding-read cap; stop_reading asserted at this count
WR_MAX, 32, outstanding-write cap; stop_writing asserted at this count
WR_HIGH, 24, write count forcing a switch to write mode
WR_LOW, 8, write count allowing a return to read mode
TURN_CYCLES, 4, idle cycles in each turnaround state (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
enq_valid  in  1  request accepted into a bank queue this cycle
enq_type  in  1  req_type of the enqueued request (read=0, write=1)
enq_bank  in  BANK_W  bank index of the enqueued request
rd_pending  in  NUM_BANKS  per-bank "read queue non-empty"
wr_pending  in  NUM_BANKS  per-bank "write queue non-empty"
issue_ready  in  1  command layer accepts issue
issue_valid  out  1  grant valid
issue_bank  out  BANK_W  granted bank
issue_type  out  1  granted type (read=0, write=1)
stop_reading  out  1  mapper must not enqueue reads
stop_writing  out  1  mapper must not enqueue writes
sched_mode  out  2  FSM state: 0 READ, 1 R2W, 2 WRITE, 3 W2R
ovf_err  out  1  sticky: enqueue arrived while the corresponding stop was high

Behaviour:
- Reset (rst=0, async): state READ; rd_cnt=wr_cnt=0; both round-robin pointers 0; turn_cnt 0; mask 0; all outputs 0.

Counters:
- rd_cnt: +1 on read enqueue; -1 on a read handshake (issue_valid & issue_ready & type read).
- wr_cnt: same rule for writes.
- Enqueue and handshake of the same type in the same cycle: count unchanged.
- Counters saturate at 2^CNT_W-1 and at 0; no wrap.

Stop outputs and overflow:
- stop_reading = rd_cnt >= RD_MAX; stop_writing = wr_cnt >= WR_MAX. Both are combinational from the registered counts.
- Enqueue while the matching stop is high: the counter still increments (saturating) and ovf_err sets. ovf_err clears only on reset.

FSM (next-state evaluated every cycle, uses registered counts):
- READ:
  - wr_cnt >= WR_HIGH -> R2W.
  - Else rd_pending==0 and wr_pending!=0 -> R2W.
  - Else stay.
- R2W: turn_cnt loads TURN_CYCLES-1 on entry, decrements each cycle; when 0 -> WRITE. issue_valid=0 throughout.
- WRITE:
  - wr_pending==0 and rd_pending!=0 -> W2R.
  - Else wr_cnt <= WR_LOW and rd_pending!=0 -> W2R.
  - Else stay.
- W2R: mirror of R2W, ending in READ.
- Both pending vectors zero: stay in current mode.

Grant selection (registered outputs, 1-cycle latency):
- Choice is made from pend = (mode==READ ? rd_pending : wr_pending) & ~mask.
- Winner = first set bit at or after the pointer for that type, wrapping 15->0.
- Outputs are loaded when issue_valid==0 or a handshake occurs. issue_valid=0 if pend==0, or if the next state is a turnaround state.
- A registered valid is held stable (bank and type unchanged) until issue_ready, even if its pending bit drops or a mode switch is pending. The FSM leaves READ/WRITE only in a cycle with no outstanding unaccepted grant.
- On handshake: pointer of that type <= bank+1 mod 16; mask <= one-hot of the granted bank for exactly one cycle. This covers the queue-pop latency, so the same bank is never double-granted from a stale pending bit.
- Sustained throughput is 1 grant/cycle across different banks; a single busy bank gets 1 grant per 2 cycles.

Test Plan:
- Reset mid-operation: assert rst=0 while issue_valid=1 and wr_cnt=10 -> issue_valid, stop_* and counts read 0 immediately; sched_mode=0 after release.
- Round robin: rd_pending=16'h8003, ready=1, pending held -> issue_bank sequence 0,1,15,0,1,15…; first valid 1 cycle after pending rises.
- Write drain: enqueue 24 writes, rd_pending=16'h0001 -> sched_mode 0->1. issue_valid=0 for exactly 4 cycles, then WRITE grants. At wr_cnt=8 -> W2R, 4 idle cycles, then READ grants bank 0.
- Backpressure: enqueue 32 reads, no issue -> stop_reading=1 on the cycle after the 32nd enqueue. Issue one read -> stop_reading=0 the next cycle. Enqueue while stopped -> ovf_err=1 and stays 1.
- Hold under stall: issue_valid=1 bank 3, ready=0 for 5 cycles while rd_pending changes to 16'h0010 -> issue_bank stays 3. On ready, the next grant is bank 4.
- Simultaneous enqueue and issue of reads at rd_cnt=5 -> rd_cnt stays 5.
